dispatch_unpacker: RTL and testbench
====================================

// Module: dispatch_unpacker
// PURPOSE
//   Parametrised instruction unpacker for the dispatch source path. Accepts a packed word stream
//   (valid/ready), reassembles variable-length dispatch instructions MSB-first, and executes them
//   against the network: input spikes, multi-cycle RUN countdown, clear, and sync handoff to the
//   sink. Supports 2-bit (source/sink) and 3-bit (procedure, reserved R04-R07) opcode modes.
// PARAMETERS
//   OPC_WIDTH     2    opcode bits: 2 -> RUN/SPK/SNC/CLR; 3 -> also R04..R07 (reserved)
//   PKT_WIDTH     8    input word width, bits
//   NUM_INP       16   network input count; IDX_WIDTH = $clog2(NUM_INP) (localparam)
//   CHARGE_WIDTH  8    spike charge width, bits
//   RUN_WIDTH     16   RUN cycle-count width, bits
// PORTS
//   clk          in   1             clock
//   arst         in   1             asynchronous reset, active-high
//   pkt_valid    in   1             input word valid
//   pkt_ready    out  1             unpacker accepts a word this cycle
//   pkt_data     in   PKT_WIDTH     input word
//   net_ready    in   1             network can take a run step this cycle
//   net_run      out  1             one network step (pulse)
//   net_clr      out  1             clear network state (pulse)
//   net_inp_en   out  1             apply spike (pulse)
//   net_inp_idx  out  IDX_WIDTH     spike input index
//   net_inp_chg  out  CHARGE_WIDTH  spike charge
//   snc_valid    out  1             sync request to sink
//   snc_ready    in   1             sink accepts sync
//   rsv_opc      out  1             reserved opcode R04..R07 consumed (pulse)
// BEHAVIOUR
//   Reset: state IDLE; every output 0 except pkt_ready (0 during reset, 1 first cycle after);
//     partial instruction and RUN count discarded; mid-operation reset aborts with no trailing pulses.
//   Format: opcode in instruction MSBs; length L = OPC_WIDTH + operand bits:
//     RUN: RUN_WIDTH count; SPK: IDX_WIDTH index then CHARGE_WIDTH charge; SNC/CLR/R0x: none.
//     Words = ceil(L/PKT_WIDTH); last word's unused LSBs ignored. Defaults: SPK 2 words, RUN 3, others 1.
//   Word transfer when pkt_valid & pkt_ready. pkt_ready = 1 only in IDLE and GATHER.
//   FSM:
//     IDLE    : word accepted -> decode opcode from pkt_data MSBs; 1-word instr -> DISPATCH,
//               else load shift register, word counter = words-1 -> GATHER.
//     GATHER  : each accepted word shifts in; counter hits 0 -> DISPATCH. pkt_valid gaps just wait.
//     DISPATCH: exactly one cycle after final word accepted. SPK: net_inp_en=1, idx/chg valid this
//               cycle only (idx >= NUM_INP still forwarded; network ignores). CLR: net_clr=1.
//               R0x: rsv_opc=1. All -> IDLE. RUN: count==0 -> IDLE; else -> RUN. SNC -> SYNC.
//     RUN     : net_run = net_ready; count decrements on each pulse; after pulse at count==1 -> IDLE.
//               net_ready low stalls with no pulse, count held.
//     SYNC    : snc_valid=1 until snc_ready; handshake cycle -> IDLE (snc_valid drops next cycle).
//   Outputs registered; net_inp_idx/chg hold last value, sampled only with net_inp_en.
//   At most one of net_run/net_clr/net_inp_en/rsv_opc high per cycle.
//   OPC_WIDTH==2: R04..R07 unencodable, rsv_opc constant 0.
//   Full-width RUN (2^RUN_WIDTH-1) must not wrap; counter RUN_WIDTH bits.
//   Throughput: back-to-back 1-word instrs every 2 cycles (IDLE, DISPATCH).
// TESTING
//   Defaults. SPK: 0x55,0xFC -> one cycle after 2nd word net_inp_en=1, idx=5, chg=0x7F; rsv_opc=0.
//   RUN 3: 0x00,0x00,0xC0, net_ready=1 -> 3 consecutive net_run pulses from DISPATCH+1; pkt_ready
//     low until IDLE. Repeat with net_ready low 2 cycles mid-run -> still exactly 3 pulses.
//   RUN 0: 0x00,0x00,0x00 -> no net_run; pkt_ready high 2 cycles after last word.
//   SNC 0x80 then CLR 0xC0, snc_ready held low 5 cycles -> snc_valid high until snc_ready; CLR
//     not accepted until then; net_clr pulses once one cycle after CLR word.
//   OPC_WIDTH=3: 0xA0 (R05) -> rsv_opc pulse, no net action; 0x20 (SPK, 3-bit opc) decodes as SPK.
//   arst asserted during RUN (count 0x8000) and mid-GATHER -> all outputs 0 immediately; next 0xC0
//     after release yields single net_clr, no stale pulses.

Source files
------------

// File: rtl/dispatch_unpacker.sv
// Dispatch-path instruction unpacker: reassembles MSB-first packed instructions from a word
// stream and drives spike, run, clear and sync actions into the network.
module dispatch_unpacker #(
    parameter int unsigned OPC_WIDTH    = 2,
    parameter int unsigned PKT_WIDTH    = 8,
    parameter int unsigned NUM_INP      = 16,
    parameter int unsigned CHARGE_WIDTH = 8,
    parameter int unsigned RUN_WIDTH    = 16,
    localparam int unsigned IDX_WIDTH   = $clog2(NUM_INP)
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    pkt_valid,
    output logic                    pkt_ready,
    input  logic [PKT_WIDTH-1:0]    pkt_data,
    input  logic                    net_ready,
    output logic                    net_run,
    output logic                    net_clr,
    output logic                    net_inp_en,
    output logic [IDX_WIDTH-1:0]    net_inp_idx,
    output logic [CHARGE_WIDTH-1:0] net_inp_chg,
    output logic                    snc_valid,
    input  logic                    snc_ready,
    output logic                    rsv_opc
);

    localparam int unsigned LEN_RUN    = OPC_WIDTH + RUN_WIDTH;
    localparam int unsigned LEN_SPK    = OPC_WIDTH + IDX_WIDTH + CHARGE_WIDTH;
    localparam int unsigned WORDS_RUN  = (LEN_RUN + PKT_WIDTH - 1) / PKT_WIDTH;
    localparam int unsigned WORDS_SPK  = (LEN_SPK + PKT_WIDTH - 1) / PKT_WIDTH;
    localparam int unsigned WORDS_MAX  = (WORDS_RUN > WORDS_SPK) ? WORDS_RUN : WORDS_SPK;
    localparam int unsigned SR_WORDS   = (WORDS_MAX > 1) ? WORDS_MAX - 1 : 1;
    localparam int unsigned SR_WIDTH   = SR_WORDS * PKT_WIDTH;
    localparam int unsigned WCNT_WIDTH = $clog2(WORDS_MAX + 1);
    // Operand fields sit right below the opcode in the left-justified, fully gathered instruction
    localparam int unsigned RUN_TOP    = WORDS_RUN * PKT_WIDTH - 1 - OPC_WIDTH;
    localparam int unsigned SPK_TOP    = WORDS_SPK * PKT_WIDTH - 1 - OPC_WIDTH;

    localparam logic [OPC_WIDTH-1:0] OPC_RUN = OPC_WIDTH'(0);
    localparam logic [OPC_WIDTH-1:0] OPC_SPK = OPC_WIDTH'(1);
    localparam logic [OPC_WIDTH-1:0] OPC_SNC = OPC_WIDTH'(2);
    localparam logic [OPC_WIDTH-1:0] OPC_CLR = OPC_WIDTH'(3);

    typedef enum logic [2:0] {StIdle, StGather, StDispatch, StRun, StSync} state_t;

    state_t                  state_q;
    logic [OPC_WIDTH-1:0]    opc_q;
    logic [WCNT_WIDTH-1:0]   wcnt_q;
    logic [SR_WIDTH-1:0]     sr_q;
    logic [RUN_WIDTH-1:0]    run_cnt_q;

    logic                          accept;
    logic                          is_last;
    logic                          is_rsv;
    logic [OPC_WIDTH-1:0]          cur_opc;
    logic [WCNT_WIDTH-1:0]         words;
    logic [SR_WIDTH+PKT_WIDTH-1:0] nxt;
    logic                          unused_nxt;

    assign pkt_ready = ~arst & ((state_q == StIdle) | (state_q == StGather));
    assign net_run   = (state_q == StRun) & net_ready;
    assign snc_valid = (state_q == StSync);

    assign accept     = pkt_valid & pkt_ready;
    assign nxt        = {sr_q, pkt_data};
    assign unused_nxt = ^nxt;
    assign cur_opc    = (state_q == StIdle) ? pkt_data[PKT_WIDTH-1 -: OPC_WIDTH] : opc_q;
    assign is_rsv     = (OPC_WIDTH > 2) && (32'(cur_opc) >= 32'd4);

    always_comb begin
        words = WCNT_WIDTH'(1);
        if (cur_opc == OPC_RUN) begin
            words = WCNT_WIDTH'(WORDS_RUN);
        end else if (cur_opc == OPC_SPK) begin
            words = WCNT_WIDTH'(WORDS_SPK);
        end
    end

    assign is_last = accept && (((state_q == StIdle) && (words == WCNT_WIDTH'(1))) ||
                                ((state_q == StGather) && (wcnt_q == WCNT_WIDTH'(1))));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= StIdle;
            opc_q       <= '0;
            wcnt_q      <= '0;
            sr_q        <= '0;
            run_cnt_q   <= '0;
            net_clr     <= 1'b0;
            net_inp_en  <= 1'b0;
            net_inp_idx <= '0;
            net_inp_chg <= '0;
            rsv_opc     <= 1'b0;
        end else begin
            net_clr    <= 1'b0;
            net_inp_en <= 1'b0;
            rsv_opc    <= 1'b0;
            unique case (state_q)
                StIdle, StGather: begin
                    if (accept) begin
                        sr_q <= nxt[SR_WIDTH-1:0];
                        if (state_q == StIdle) begin
                            opc_q  <= cur_opc;
                            wcnt_q <= words - WCNT_WIDTH'(1);
                        end else begin
                            wcnt_q <= wcnt_q - WCNT_WIDTH'(1);
                        end
                        if (is_last) begin
                            state_q <= StDispatch;
                            if (cur_opc == OPC_SPK) begin
                                net_inp_en  <= 1'b1;
                                net_inp_idx <= nxt[SPK_TOP -: IDX_WIDTH];
                                net_inp_chg <= nxt[SPK_TOP - IDX_WIDTH -: CHARGE_WIDTH];
                            end else if (cur_opc == OPC_CLR) begin
                                net_clr <= 1'b1;
                            end else if (is_rsv) begin
                                rsv_opc <= 1'b1;
                            end else if (cur_opc == OPC_RUN) begin
                                run_cnt_q <= nxt[RUN_TOP -: RUN_WIDTH];
                            end
                        end else begin
                            state_q <= StGather;
                        end
                    end
                end
                StDispatch: begin
                    if (opc_q == OPC_RUN) begin
                        state_q <= (run_cnt_q == '0) ? StIdle : StRun;
                    end else if (opc_q == OPC_SNC) begin
                        state_q <= StSync;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    if (net_ready) begin
                        run_cnt_q <= run_cnt_q - RUN_WIDTH'(1);
                        if (run_cnt_q == RUN_WIDTH'(1)) begin
                            state_q <= StIdle;
                        end
                    end
                end
                StSync: begin
                    if (snc_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dispatch_unpacker.sv
// Bench for dispatch_unpacker: vector table, directed timing sequences and a randomized
// instruction stream checked against an event-level reference model.
module tb_dispatch_unpacker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       arst;
    logic       pkt_valid, pkt_ready;
    logic [7:0] pkt_data;
    logic       net_ready, net_run, net_clr, net_inp_en;
    logic [3:0] net_inp_idx;
    logic [7:0] net_inp_chg;
    logic       snc_valid, snc_ready, rsv_opc;

    logic       pkt_valid_3, pkt_ready_3;
    logic [7:0] pkt_data_3;
    logic       net_run_3, net_clr_3, net_inp_en_3, snc_valid_3, rsv_opc_3;
    logic [3:0] net_inp_idx_3;
    logic [7:0] net_inp_chg_3;

    dispatch_unpacker dut (
        .clk(clk), .arst(arst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_data(pkt_data), .net_ready(net_ready), .net_run(net_run), .net_clr(net_clr),
        .net_inp_en(net_inp_en), .net_inp_idx(net_inp_idx), .net_inp_chg(net_inp_chg),
        .snc_valid(snc_valid), .snc_ready(snc_ready), .rsv_opc(rsv_opc)
    );

    dispatch_unpacker #(.OPC_WIDTH(3)) dut3 (
        .clk(clk), .arst(arst), .pkt_valid(pkt_valid_3), .pkt_ready(pkt_ready_3),
        .pkt_data(pkt_data_3), .net_ready(1'b1), .net_run(net_run_3), .net_clr(net_clr_3),
        .net_inp_en(net_inp_en_3), .net_inp_idx(net_inp_idx_3), .net_inp_chg(net_inp_chg_3),
        .snc_valid(snc_valid_3), .snc_ready(1'b1), .rsv_opc(rsv_opc_3)
    );

    int passed = 0;
    int total = 0;
    int onehot_viol = 0;
    logic [31:0] obs[$];
    logic [31:0] exp_q[$];
    bit rnd_on = 1'b0;

    // Event kinds: 1 spike, 2 clear, 3 run step, 4 sync handshake, 5 reserved opcode
    function automatic logic [31:0] ev(input int t, input int idx, input int chg);
        return {8'(t), 8'(idx), 16'(chg)};
    endfunction

    always @(negedge clk) begin
        if (!arst) begin
            if ($countones({net_run, net_clr, net_inp_en, rsv_opc}) > 1) onehot_viol++;
            if (net_inp_en) obs.push_back(ev(1, int'(net_inp_idx), int'(net_inp_chg)));
            if (net_clr) obs.push_back(ev(2, 0, 0));
            if (net_run) obs.push_back(ev(3, 0, 0));
            if (snc_valid && snc_ready) obs.push_back(ev(4, 0, 0));
            if (rsv_opc) obs.push_back(ev(5, 0, 0));
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        bit done = 1'b0;
        pkt_valid = 1'b1;
        pkt_data  = w;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (pkt_ready) done = 1'b1;
        end
        tick();
        pkt_valid = 1'b0;
        if (!done) begin
            total++;
            $display("FAIL send_timeout: word 0x%0h never accepted", w);
        end
    endtask

    task automatic send_word_3(input logic [7:0] w);
        bit done = 1'b0;
        pkt_valid_3 = 1'b1;
        pkt_data_3  = w;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (pkt_ready_3) done = 1'b1;
        end
        tick();
        pkt_valid_3 = 1'b0;
        if (!done) begin
            total++;
            $display("FAIL send3_timeout: word 0x%0h never accepted", w);
        end
    endtask

    task automatic compare_events(input string name);
        check({name, "_count"}, obs.size(), exp_q.size());
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            check(name, obs[i], exp_q[i]);
        end
    endtask

    // Left-justified instruction bits for the default 2-bit opcode build, junk in unused LSBs
    task automatic pack(input int kind, input int a, input int b,
                        output logic [23:0] bits, output int n);
        logic [5:0] junk;
        junk = 6'($urandom);
        case (kind)
            0: begin bits = {2'b00, 16'(a), junk}; n = 3; end
            1: begin bits = {2'b01, 4'(a), 8'(b), junk[1:0], 8'h00}; n = 2; end
            2: begin bits = {2'b10, junk, 16'h0}; n = 1; end
            default: begin bits = {2'b11, junk, 16'h0}; n = 1; end
        endcase
    endtask

    typedef struct {
        string       name;
        int          nw;
        logic [23:0] words;
        int          kind;
        int          idx;
        int          chg;
        int          runs;
    } vec_t;

    vec_t tbl[9];
    logic [31:0] outs;
    int cnt;

    initial begin
        tbl[0] = '{"spk_5_7f",    2, 24'h55FC00, 1, 5,  8'h7F, 0};
        tbl[1] = '{"run_3",       3, 24'h0000C0, 3, 0,  0,     3};
        tbl[2] = '{"run_0",       3, 24'h000000, 0, 0,  0,     0};
        tbl[3] = '{"clr",         1, 24'hC00000, 2, 0,  0,     0};
        tbl[4] = '{"spk_15_00",   2, 24'h7C0300, 1, 15, 8'h00, 0};
        tbl[5] = '{"spk_0_ff",    2, 24'h43FF00, 1, 0,  8'hFF, 0};
        tbl[6] = '{"run_1",       3, 24'h000040, 3, 0,  0,     1};
        tbl[7] = '{"run_5",       3, 24'h000140, 3, 0,  0,     5};
        tbl[8] = '{"snc",         1, 24'h800000, 4, 0,  0,     0};

        arst = 1'b1; pkt_valid = 1'b0; pkt_data = '0; net_ready = 1'b1; snc_ready = 1'b1;
        pkt_valid_3 = 1'b0; pkt_data_3 = '0;

        // Reset state
        repeat (2) @(negedge clk);
        outs = {13'd0, net_run, net_clr, net_inp_en, net_inp_idx, net_inp_chg, snc_valid,
                rsv_opc, pkt_ready};
        check("reset_outputs", outs, 0);
        check("reset_ready_3", pkt_ready_3, 0);
        tick();
        arst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", pkt_ready, 1);
        check("ready_after_reset_3", pkt_ready_3, 1);
        tick();

        // Vector table
        for (int v = 0; v < 9; v++) begin
            obs.delete();
            exp_q.delete();
            for (int w = 0; w < tbl[v].nw; w++) send_word(tbl[v].words[23 - 8 * w -: 8]);
            repeat (12) tick();
            if (tbl[v].kind == 1) exp_q.push_back(ev(1, tbl[v].idx, tbl[v].chg));
            if (tbl[v].kind == 2) exp_q.push_back(ev(2, 0, 0));
            if (tbl[v].kind == 4) exp_q.push_back(ev(4, 0, 0));
            for (int r = 0; r < tbl[v].runs; r++) exp_q.push_back(ev(3, 0, 0));
            compare_events(tbl[v].name);
        end

        // SPK timing: pulse one cycle after last word, idx/chg held afterwards
        send_word(8'h55);
        send_word(8'hFC);
        @(negedge clk);
        check("spk_en", net_inp_en, 1);
        check("spk_idx", net_inp_idx, 5);
        check("spk_chg", net_inp_chg, 8'h7F);
        check("spk_rsv", rsv_opc, 0);
        @(negedge clk);
        check("spk_en_drop", net_inp_en, 0);
        check("spk_idx_hold", net_inp_idx, 5);
        tick();

        // RUN 3 timing
        send_word(8'h00); send_word(8'h00); send_word(8'hC0);
        @(negedge clk);
        check("run3_dispatch_run", net_run, 0);
        check("run3_dispatch_ready", pkt_ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("run3_pulse", net_run, 1);
            check("run3_busy", pkt_ready, 0);
        end
        @(negedge clk);
        check("run3_done_run", net_run, 0);
        check("run3_done_ready", pkt_ready, 1);
        tick();

        // RUN 3 with a two-cycle net_ready stall after the first pulse
        obs.delete();
        send_word(8'h00); send_word(8'h00); send_word(8'hC0);
        tick();
        tick();
        net_ready = 1'b0;
        @(negedge clk);
        check("stall_no_pulse", net_run, 0);
        tick();
        tick();
        net_ready = 1'b1;
        repeat (8) tick();
        check("stall_run_count", obs.size(), 3);

        // RUN 0: ready again two cycles after the last word
        send_word(8'h00); send_word(8'h00); send_word(8'h00);
        @(negedge clk);
        check("run0_dispatch_ready", pkt_ready, 0);
        @(negedge clk);
        check("run0_ready", pkt_ready, 1);
        check("run0_no_run", net_run, 0);
        tick();

        // SNC with sink stalled, CLR queued behind it
        obs.delete();
        exp_q.delete();
        snc_ready = 1'b0;
        send_word(8'h80);
        pkt_valid = 1'b1;
        pkt_data  = 8'hC0;
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("snc_hold_valid", snc_valid, 1);
            check("snc_hold_blocked", pkt_ready, 0);
        end
        tick();
        snc_ready = 1'b1;
        @(negedge clk);
        check("snc_handshake", snc_valid, 1);
        tick();
        snc_ready = 1'b0;
        @(negedge clk);
        check("snc_dropped", snc_valid, 0);
        check("clr_ready", pkt_ready, 1);
        tick();
        pkt_valid = 1'b0;
        @(negedge clk);
        check("clr_pulse", net_clr, 1);
        @(negedge clk);
        check("clr_single", net_clr, 0);
        snc_ready = 1'b1;
        exp_q.push_back(ev(4, 0, 0));
        exp_q.push_back(ev(2, 0, 0));
        compare_events("snc_then_clr");
        tick();

        // Back-to-back single-word instructions every two cycles
        cnt = 0;
        pkt_valid = 1'b1;
        pkt_data  = 8'hC0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (net_clr) cnt++;
        end
        tick();
        pkt_valid = 1'b0;
        check("b2b_clr_count", cnt, 4);
        repeat (3) tick();

        // 3-bit opcode build: reserved R05 and SPK
        send_word_3(8'hA0);
        @(negedge clk);
        check("r05_rsv", rsv_opc_3, 1);
        check("r05_no_net", {net_run_3, net_clr_3, net_inp_en_3, snc_valid_3}, 0);
        @(negedge clk);
        check("r05_rsv_drop", rsv_opc_3, 0);
        tick();
        send_word_3(8'h20);
        send_word_3(8'hFE);
        @(negedge clk);
        check("opc3_spk_en", net_inp_en_3, 1);
        check("opc3_spk_idx", net_inp_idx_3, 0);
        check("opc3_spk_chg", net_inp_chg_3, 8'h7F);
        check("opc3_spk_rsv", rsv_opc_3, 0);
        tick();

        // Reset during a long RUN
        send_word(8'h20); send_word(8'h00); send_word(8'h00);
        repeat (5) tick();
        #2;
        arst = 1'b1;
        #1;
        outs = {15'd0, net_run, net_clr, net_inp_en, net_inp_idx, net_inp_chg, snc_valid,
                rsv_opc, pkt_ready};
        check("arst_run_outputs", outs, 0);
        tick();
        tick();
        arst = 1'b0;
        obs.delete();
        exp_q.delete();
        exp_q.push_back(ev(2, 0, 0));
        send_word(8'hC0);
        repeat (5) tick();
        compare_events("after_run_reset");

        // Reset mid-GATHER
        send_word(8'h55);
        #2;
        arst = 1'b1;
        #1;
        check("arst_gather_ready", pkt_ready, 0);
        tick();
        tick();
        arst = 1'b0;
        obs.delete();
        send_word(8'hC0);
        repeat (5) tick();
        compare_events("after_gather_reset");

        // Randomized instruction stream against the event model
        obs.delete();
        exp_q.delete();
        rnd_on = 1'b1;
        fork
            begin
                logic [23:0] bits;
                int n, kind, a, b;
                for (int i = 0; i < 60; i++) begin
                    kind = int'($urandom_range(0, 3));
                    a = (kind == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 15));
                    b = int'($urandom_range(0, 255));
                    case (kind)
                        0: for (int r = 0; r < a; r++) exp_q.push_back(ev(3, 0, 0));
                        1: exp_q.push_back(ev(1, a, b));
                        2: exp_q.push_back(ev(4, 0, 0));
                        default: exp_q.push_back(ev(2, 0, 0));
                    endcase
                    pack(kind, a, b, bits, n);
                    for (int w = 0; w < n; w++) begin
                        repeat ($urandom_range(0, 2)) tick();
                        send_word(bits[23 - 8 * w -: 8]);
                    end
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    tick();
                    net_ready = ($urandom_range(0, 3) != 0);
                    snc_ready = ($urandom_range(0, 2) != 0);
                end
                net_ready = 1'b1;
                snc_ready = 1'b1;
            end
        join
        for (int i = 0; i < 3000 && obs.size() < exp_q.size(); i++) tick();
        repeat (10) tick();
        compare_events("random");

        check("onehot_pulses", onehot_viol, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
